// File: rtl/multi_port_fifo_pkg.sv
// Shared definitions for multi-lane superscalar buffers: default geometry,
// counter/lane-count width helpers and the lane-offset helper.
package multi_port_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_N_ENQ      = 2;
    localparam int DEF_N_DEQ      = 2;

    // One extra bit beyond the pointer so full and empty are distinguishable.
    function automatic int ctr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width able to hold 0..lanes.
    function automatic int lane_cnt_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/fifo_multi_ctr.sv
// Wrapping counter that advances by a variable amount each cycle, with a
// synchronous clear that takes priority over the increment.
module fifo_multi_ctr #(
    parameter int WIDTH     = 4,
    parameter int INC_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_aL,
    input  logic                 clr,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [WIDTH-1:0]     value
);

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else begin
            value <= value + WIDTH'(inc);
        end
    end

endmodule

// File: rtl/multi_port_fifo.sv
// In-order FIFO with N_ENQ enqueue and N_DEQ dequeue lanes per cycle.
// Define MPFIFO_FLUSH_EN to add the synchronous flush port.
module multi_port_fifo
    import multi_port_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int N_ENQ      = DEF_N_ENQ,
    parameter int N_DEQ      = DEF_N_DEQ
) (
    input  logic                              clk,
    input  logic                              rst_aL,
`ifdef MPFIFO_FLUSH_EN
    input  logic                              flush,
`endif
    output logic [N_ENQ-1:0]                  ready_enq,
    input  logic [N_ENQ-1:0]                  valid_enq,
    input  logic [N_ENQ*DATA_WIDTH-1:0]       data_enq,
    output logic [N_DEQ-1:0]                  valid_deq,
    input  logic [N_DEQ-1:0]                  ready_deq,
    output logic [N_DEQ*DATA_WIDTH-1:0]       data_deq,
    output logic [ctr_width(FIFO_DEPTH)-1:0]  count
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CTR_WIDTH = ctr_width(FIFO_DEPTH);
    localparam int ENQ_CW    = lane_cnt_width(N_ENQ);
    localparam int DEQ_CW    = lane_cnt_width(N_DEQ);

    logic [CTR_WIDTH-1:0]  enq_ctr;
    logic [CTR_WIDTH-1:0]  deq_ctr;
    logic [CTR_WIDTH-1:0]  free;
    logic [PTR_WIDTH-1:0]  enq_ptr;
    logic [PTR_WIDTH-1:0]  deq_ptr;
    logic [ENQ_CW-1:0]     n_enq;
    logic [DEQ_CW-1:0]     n_deq;
    logic                  enq_run;
    logic                  deq_run;
    logic                  clr;
    logic [N_ENQ-1:0]      wr_en;
    logic [PTR_WIDTH-1:0]  wr_idx [N_ENQ];
    logic [PTR_WIDTH-1:0]  rd_idx [N_DEQ];
    logic [DATA_WIDTH-1:0] mem    [FIFO_DEPTH];

    assign enq_ptr = enq_ctr[PTR_WIDTH-1:0];
    assign deq_ptr = deq_ctr[PTR_WIDTH-1:0];
    assign count   = enq_ctr - deq_ctr;
    assign free    = CTR_WIDTH'(FIFO_DEPTH) - count;

`ifdef MPFIFO_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    // Handshake: a lane transfers when valid & ready on that lane and on every
    // lower lane; ready_enq/valid_deq depend only on registered state, so
    // valid_enq and ready_deq never reach an output combinationally.
    always_comb begin
        for (int i = 0; i < N_ENQ; i++) begin
            ready_enq[i] = (free > CTR_WIDTH'(i));
        end
        for (int i = 0; i < N_DEQ; i++) begin
            valid_deq[i] = (count > CTR_WIDTH'(i));
        end
    end

    always_comb begin
        n_enq   = '0;
        enq_run = 1'b1;
        for (int i = 0; i < N_ENQ; i++) begin
            enq_run = enq_run & valid_enq[i] & ready_enq[i];
            if (enq_run) n_enq = ENQ_CW'(i + 1);
        end
        n_deq   = '0;
        deq_run = 1'b1;
        for (int i = 0; i < N_DEQ; i++) begin
            deq_run = deq_run & valid_deq[i] & ready_deq[i];
            if (deq_run) n_deq = DEQ_CW'(i + 1);
        end
    end

    always_comb begin
        for (int k = 0; k < N_ENQ; k++) begin
            wr_en[k]  = (ENQ_CW'(k) < n_enq);
            wr_idx[k] = enq_ptr + PTR_WIDTH'(k);
        end
`ifdef MPFIFO_FLUSH_EN
        if (flush) wr_en = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            for (int k = 0; k < N_ENQ; k++) begin
                if (wr_en[k]) mem[wr_idx[k]] <= data_enq[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    // One read mux per dequeue lane; pointer arithmetic wraps naturally.
    always_comb begin
        for (int i = 0; i < N_DEQ; i++) begin
            rd_idx[i] = deq_ptr + PTR_WIDTH'(i);
            data_deq[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = mem[rd_idx[i]];
        end
    end

    fifo_multi_ctr #(.WIDTH(CTR_WIDTH), .INC_WIDTH(ENQ_CW)) u_enq_ctr (
        .clk    (clk),
        .rst_aL (rst_aL),
        .clr    (clr),
        .inc    (n_enq),
        .value  (enq_ctr)
    );

    fifo_multi_ctr #(.WIDTH(CTR_WIDTH), .INC_WIDTH(DEQ_CW)) u_deq_ctr (
        .clk    (clk),
        .rst_aL (rst_aL),
        .clr    (clr),
        .inc    (n_deq),
        .value  (deq_ctr)
    );

endmodule

// File: tb/tb_multi_port_fifo.sv
// Self-checking bench for multi_port_fifo at default geometry (32b x 8, 2+2 lanes).
module tb_multi_port_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_aL = 1'b0;
    logic [1:0]  valid_enq = '0;
    logic [1:0]  ready_deq = '0;
    logic [63:0] data_enq = '0;
    logic [1:0]  ready_enq;
    logic [1:0]  valid_deq;
    logic [63:0] data_deq;
    logic [3:0]  count;
`ifdef MPFIFO_FLUSH_EN
    logic        flush = 1'b0;
`endif

    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int total_enq = 0;
    int seq = 0;

    typedef struct {
        logic [1:0] ve;
        logic [1:0] rd;
        int         exp_count;
    } vec_t;
    vec_t vecs[20];

    multi_port_fifo dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
`ifdef MPFIFO_FLUSH_EN
        .flush     (flush),
`endif
        .ready_enq (ready_enq),
        .valid_enq (valid_enq),
        .data_enq  (data_enq),
        .valid_deq (valid_deq),
        .ready_deq (ready_deq),
        .data_deq  (data_deq),
        .count     (count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drives one cycle starting at a negedge: checks outputs against the
    // queue model, then applies the prefix-ordered transfer rules to it.
    task automatic step(input logic [1:0] ve, input logic [1:0] rd,
                        input logic [31:0] d0, input logic [31:0] d1, input logic fl);
        int ne;
        int nd;
        int sz;
        logic [1:0] er;
        logic [1:0] ev;
        valid_enq = ve;
        ready_deq = rd;
        data_enq  = {d1, d0};
`ifdef MPFIFO_FLUSH_EN
        flush = fl;
`endif
        #1;
        sz = exp_q.size();
        for (int i = 0; i < 2; i++) begin
            er[i] = (DEPTH - sz) > i;
            ev[i] = sz > i;
        end
        check("count", 64'(count), 64'(sz));
        check("ready_enq", 64'(ready_enq), 64'(er));
        check("valid_deq", 64'(valid_deq), 64'(ev));
        for (int i = 0; i < 2; i++) begin
            if (i < sz) check("data_deq", 64'(data_deq[i*DW +: DW]), 64'(exp_q[i]));
        end
        ne = 0;
        nd = 0;
        for (int i = 0; i < 2; i++) begin
            if (ne == i && ve[i] && er[i]) ne++;
            if (nd == i && rd[i] && ev[i]) nd++;
        end
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            total_enq = 0;
        end else begin
            repeat (nd) void'(exp_q.pop_front());
            if (ne > 0) exp_q.push_back(d0);
            if (ne > 1) exp_q.push_back(d1);
            total_enq += ne;
        end
        @(negedge clk);
`ifdef MPFIFO_FLUSH_EN
        flush = 1'b0;
`endif
    endtask

    task automatic step_seq(input logic [1:0] ve, input logic [1:0] rd);
        step(ve, rd, 32'hA000_0000 + 32'(seq), 32'hA000_0000 + 32'(seq + 1), 1'b0);
        seq += 2;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = '{2'b11, 2'b00, 2};
        vecs[1]  = '{2'b11, 2'b00, 4};
        vecs[2]  = '{2'b11, 2'b00, 6};
        vecs[3]  = '{2'b11, 2'b00, 8};
        vecs[4]  = '{2'b11, 2'b00, 8};   // full: nothing accepted
        vecs[5]  = '{2'b11, 2'b11, 6};   // full: dequeue only
        vecs[6]  = '{2'b00, 2'b00, 6};
        vecs[7]  = '{2'b10, 2'b00, 6};   // lane 0 idle blocks lane 1
        vecs[8]  = '{2'b00, 2'b10, 6};   // lane 0 not ready blocks lane 1
        vecs[9]  = '{2'b01, 2'b01, 6};
        vecs[10] = '{2'b11, 2'b01, 7};
        vecs[11] = '{2'b11, 2'b00, 8};   // one free slot: only lane 0
        vecs[12] = '{2'b00, 2'b11, 6};
        vecs[13] = '{2'b11, 2'b11, 6};
        vecs[14] = '{2'b00, 2'b11, 4};
        vecs[15] = '{2'b00, 2'b11, 2};
        vecs[16] = '{2'b00, 2'b01, 1};
        vecs[17] = '{2'b01, 2'b11, 1};   // one entry: only lane 0 dequeues
        vecs[18] = '{2'b00, 2'b11, 0};
        vecs[19] = '{2'b00, 2'b11, 0};

        // Reset values, checked while reset is held.
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid_deq", 64'(valid_deq), 64'd0);
        check("rst_ready_enq", 64'(ready_enq), 64'h3);
        check("rst_data_deq", data_deq, 64'd0);
        @(negedge clk);
        rst_aL = 1'b1;
        @(negedge clk);
        step_seq(2'b00, 2'b00);
        check("idle_data_deq", data_deq, 64'd0);

        // Directed table.
        for (int v = 0; v < 20; v++) begin
            step_seq(vecs[v].ve, vecs[v].rd);
            check("tbl_count", 64'(count), 64'(vecs[v].exp_count));
        end

        // Randomised traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
        end

        // Wrap: drain, bring both pointers to 7, then write across 7 -> 0.
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) step_seq(2'b00, 2'b11);
        for (int t = 0; t < 8 && (total_enq % DEPTH) != 7; t++) begin
            step_seq(2'b01, 2'b00);
            step_seq(2'b00, 2'b11);
        end
        check("wrap_ptr_count", 64'(count), 64'd0);
        step(2'b11, 2'b00, 32'hB000_0000, 32'hB000_0001, 1'b0);
        check("wrap_data_deq", data_deq, {32'hB000_0001, 32'hB000_0000});
        check("wrap_valid_deq", 64'(valid_deq), 64'h3);

`ifdef MPFIFO_FLUSH_EN
        step_seq(2'b11, 2'b00);
        step_seq(2'b01, 2'b00);
        check("pre_flush_count", 64'(count), 64'd5);
        step(2'b11, 2'b11, 32'hC000_0000, 32'hC000_0001, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid_deq", 64'(valid_deq), 64'd0);
        check("flush_ready_enq", 64'(ready_enq), 64'h3);
        step_seq(2'b11, 2'b00);
        step_seq(2'b00, 2'b00);
`endif

        // Asynchronous reset mid-operation discards everything at once.
        step_seq(2'b11, 2'b00);
        step_seq(2'b11, 2'b00);
        valid_enq = 2'b00;
        ready_deq = 2'b00;
        #2;
        rst_aL = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_valid_deq", 64'(valid_deq), 64'd0);
        check("async_rst_ready_enq", 64'(ready_enq), 64'h3);
        check("async_rst_data_deq", data_deq, 64'd0);
        exp_q.delete();
        total_enq = 0;
        @(negedge clk);
        rst_aL = 1'b1;
        @(negedge clk);
        step_seq(2'b11, 2'b00);
        step_seq(2'b11, 2'b11);
        step_seq(2'b00, 2'b11);
        step_seq(2'b00, 2'b00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multi_port_fifo.md
# multi_port_fifo

Parametrised in-order FIFO with N_ENQ enqueue lanes and N_DEQ dequeue lanes per cycle, for superscalar front-end and dispatch buffering (fetch→decode, decode→dispatch). It generalises the single-lane FIFO to:
- variable per-cycle throughput on each side,
- an occupancy count output,
- an optional synchronous flush for misprediction recovery.

Storage is a flat register array addressed by wrapping pointers.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per entry
- FIFO_DEPTH, 8, entries; power of two, ≥ max(N_ENQ, N_DEQ)
- N_ENQ, 2, enqueue lanes
- N_DEQ, 2, dequeue lanes
- PTR_WIDTH (local), $clog2(FIFO_DEPTH)
- CTR_WIDTH (local), PTR_WIDTH+1

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_aL  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; present only with MPFIFO_FLUSH_EN
- ready_enq  out  N_ENQ  lane i may enqueue this cycle
- valid_enq  in  N_ENQ  lane i offers data
- data_enq  in  N_ENQ*DATA_WIDTH  lane i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- valid_deq  out  N_DEQ  lane i holds a valid entry
- ready_deq  in  N_DEQ  consumer accepts lane i
- data_deq  out  N_DEQ*DATA_WIDTH  lane i = entry at deq_ptr+i (mod depth)
- count  out  CTR_WIDTH  current occupancy, 0..FIFO_DEPTH

## Operation
- State:
  - enq_ctr, deq_ctr (CTR_WIDTH, wrap mod 2·FIFO_DEPTH)
  - pointers = low PTR_WIDTH bits of the counters
  - count = enq_ctr − deq_ctr (modular, CTR_WIDTH bits)
- ready_enq[i] = (FIFO_DEPTH − count) > i. valid_deq[i] = count > i. Both are combinational from registered state only.
- Enqueue lanes are prefix-ordered:
  - n_enq = number of leading lanes i (starting at 0) with valid_enq[i] & ready_enq[i].
  - The first lane failing this condition ends the prefix. Later lanes are ignored even if valid.
  - Lane k < n_enq writes entry (enq_ptr+k) mod FIFO_DEPTH.
- Dequeue lanes are prefix-ordered the same way: n_deq = number of leading lanes with valid_deq[i] & ready_deq[i].
- Counter update on the clock edge: enq_ctr += n_enq, deq_ctr += n_deq.
- Simultaneous enqueue and dequeue are both allowed. Readiness uses start-of-cycle count, so slots freed by a dequeue are not reusable in the same cycle. A full FIFO with an active dequeue still shows ready_enq = 0.
- Pointer wrap-around is modular. A multi-lane write or read that straddles entry FIFO_DEPTH−1 → 0 is legal and required.
- No bypass: data enqueued into an empty FIFO appears on data_deq the next cycle.
- data_deq on lanes with valid_deq = 0 is don't-care and must not be checked. Exception: immediately after reset it reads 0.
- Flush (MPFIFO_FLUSH_EN):
  - At the next edge both counters return to 0.
  - Flush has priority over same-cycle enqueue and dequeue: no entry is written and no counter advances.
  - Entry contents need not be cleared.

## Timing
- Reset, asynchronous on rst_aL = 0:
  - counters and all entries go to 0
  - count = 0, valid_deq = 0, ready_enq = all ones
- Reset mid-operation discards all contents immediately. Deassertion is synchronised externally.
- Enqueue-to-visible latency: 1 cycle. Dequeue takes effect at the edge.
- Full throughput: N_ENQ entries in and N_DEQ entries out per cycle, sustained, with no bubbles.
- There is no combinational path from valid_enq or ready_deq to any output.

## Configuration
- MPFIFO_FLUSH_EN defined: flush port exists with the behaviour above.
- Undefined: flush port is absent. Counters change only by reset, enqueue and dequeue, and the logic carries no flush term.

## Structure
- Shared package, with the lane-offset helper constant and width functions shared with other superscalar buffers:
  - default DATA_WIDTH, FIFO_DEPTH, N_ENQ, N_DEQ
  - the CTR_WIDTH derivation
- One sub-module, fifo_multi_ctr: a CTR_WIDTH counter with an asynchronous active-low reset, advancing by a variable amount (0..N). It has a synchronous clear input, tied low when the macro is off. It is instantiated twice, once for enq_ctr and once for deq_ctr.
- Storage entries reuse the existing register cell. The read side uses one mux per dequeue lane.

## Test plan
All scenarios use defaults (DATA_WIDTH 32, FIFO_DEPTH 8, N_ENQ 2, N_DEQ 2).
- Reset, then idle → count 0, valid_deq 00, ready_enq 11, data_deq = 0.
- Enqueue {A0,A1} on both lanes for 4 cycles with ready_deq = 00 → count 8, ready_enq 00. A further valid_enq = 11 changes nothing.
- From full, ready_deq = 11 with valid_enq = 11 → A0,A1 dequeued, count 6, no write that cycle. The next cycle ready_enq = 11.
- valid_enq = 10 (lane 0 idle, lane 1 valid) → nothing enqueued, count unchanged. ready_deq = 10 with count ≥ 2 → nothing dequeued.
- Wrap test: advance both pointers to 7, then enqueue {B0,B1} → B0 in entry 7, B1 in entry 0. The next cycle data_deq = {B0,B1}, valid_deq = 11.
- MPFIFO_FLUSH_EN: count 5, then assert flush together with valid_enq = 11 and ready_deq = 11 → next cycle count 0, valid_deq 00, ready_enq 11.
